// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and state encoding for the 64x8 RAM access sequencer
package mem_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int WORD_W = 2 * DATA_W;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        RD0  = 3'd3,
        RD1  = 3'd4,
        RD2  = 3'd5,
        DONE = 3'd6
    } state_t;
endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences byte/word requests into byte cycles on a 64x8 single-port RAM
//   req_*  : valid/ready request (we, word, addr, wdata), accepted only in IDLE
//   rsp_*  : one-cycle completion pulse with read data (high byte 0 for byte reads)
//   ram_*  : RAM pins, decoded from state and the latched request only; ram_q is the registered read
module ram_access_ctrl #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_word,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_q
);
    import mem_pkg::*;
    state_t state, next;
    logic lwe, lword;
    logic [ADDR_W-1:0] laddr, laddr1;
    logic [2*DATA_W-1:0] lwdata;
    // high byte of a word lives at A+1, wrapping modulo the RAM depth
    assign laddr1 = laddr + ADDR_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lwe       <= 1'b0;
            lword     <= 1'b0;
            laddr     <= '0;
            lwdata    <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= next;
            if (state == IDLE && req_valid) begin
                lwe    <= req_we;
                lword  <= req_word;
                laddr  <= req_addr;
                lwdata <= req_wdata;
            end
            if (state == RD1)
                rsp_rdata <= {lword ? rsp_rdata[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}}, ram_q};
            if (state == RD2)
                rsp_rdata[2*DATA_W-1:DATA_W] <= ram_q;
        end
    end
    always_comb begin
        next      = IDLE;
        req_ready = state == IDLE;
        rsp_valid = state == DONE;
        ram_we    = state == WR0 || state == WR1;
        ram_addr  = (state == WR0 || state == RD0) ? laddr :
                    (state == WR1 || (state == RD1 && lword)) ? laddr1 : '0;
        ram_data  = state == WR0 ? lwdata[DATA_W-1:0] :
                    state == WR1 ? lwdata[2*DATA_W-1:DATA_W] : '0;
        case (state)
            IDLE:    next = req_valid ? (req_we ? WR0 : RD0) : IDLE;
            WR0:     next = lword ? WR1 : DONE;
            WR1:     next = DONE;
            RD0:     next = RD1;
            RD1:     next = lword ? RD2 : DONE;
            RD2:     next = DONE;
            default: next = IDLE;
        endcase
    end
    logic unused_lwe;
    assign unused_lwe = lwe;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: self-checking bench with a 64x8 RAM and a transaction-level reference model
module tb_ram_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we, req_word;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic [7:0]  ram_q = 8'h00;

    always #5 clk = ~clk;

    ram_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_word(req_word),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
    );

    // RAM with registered read, plus a backdoor write port for preloading
    logic [7:0] mem [64] = '{default: 8'h00};
    logic       bd_we = 1'b0;
    logic [5:0] bd_addr = 6'd0;
    logic [7:0] bd_data = 8'h00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else ram_q <= mem[ram_addr];
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    int pulses = 0;
    always @(posedge clk) if (rsp_valid) pulses <= pulses + 1;

    int checks = 0;
    int errors = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // reference model: byte array plus last read result
    logic [7:0]  rmem [64] = '{default: 8'h00};
    logic [15:0] last_rd = 16'h0000;
    task automatic model(input logic we, input logic word, input logic [5:0] a, input logic [15:0] wd,
                         output logic [15:0] exp_rd, output int exp_lat);
        logic [5:0] a1;
        a1 = a + 6'd1;
        if (we) begin
            rmem[a] = wd[7:0];
            if (word) rmem[a1] = wd[15:8];
        end else begin
            last_rd = word ? {rmem[a1], rmem[a]} : {8'h00, rmem[a]};
        end
        exp_rd  = last_rd;
        exp_lat = 2 + int'(word) + int'(!we);
    endtask

    // one transaction started at a negedge; latency counts the accept edge as 1
    task automatic xact(input logic we, input logic word, input logic [5:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output int np);
        int n, p0;
        req_we = we; req_word = word; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        p0 = pulses;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        @(negedge clk);
        np = pulses - p0;
    endtask

    typedef struct {
        logic        we;
        logic        word;
        logic [5:0]  a;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
    } vec_t;
    vec_t tv [10];

    initial begin
        int lat, np, p0, bad, n;
        logic [15:0] rd, erd;
        int elat;
        logic w, wo;
        logic [5:0] a;
        logic [15:0] d;
        req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0; req_addr = 6'd0; req_wdata = 16'h0;
        tv[0] = '{1'b1, 1'b0, 6'd5,  16'h00A5, 16'h0000, 2};
        tv[1] = '{1'b0, 1'b0, 6'd5,  16'h0000, 16'h00A5, 3};
        tv[2] = '{1'b1, 1'b1, 6'd10, 16'h1234, 16'h00A5, 3};
        tv[3] = '{1'b0, 1'b1, 6'd10, 16'h0000, 16'h1234, 4};
        tv[4] = '{1'b0, 1'b0, 6'd5,  16'h0000, 16'h00A5, 3};
        tv[5] = '{1'b1, 1'b0, 6'd7,  16'h0055, 16'h00A5, 2};
        tv[6] = '{1'b1, 1'b1, 6'd63, 16'hBEEF, 16'h00A5, 3};
        tv[7] = '{1'b0, 1'b1, 6'd63, 16'h0000, 16'hBEEF, 4};
        tv[8] = '{1'b0, 1'b0, 6'd0,  16'h0000, 16'h00BE, 3};
        tv[9] = '{1'b0, 1'b0, 6'd11, 16'h0000, 16'h0012, 3};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            xact(tv[i].we, tv[i].word, tv[i].a, tv[i].wd, lat, rd, np);
            model(tv[i].we, tv[i].word, tv[i].a, tv[i].wd, erd, elat);
            chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d_pulses", i), np, 1);
        end
        chk("ram5", mem[5], 8'hA5);
        chk("ram10", mem[10], 8'h34);
        chk("ram11", mem[11], 8'h12);
        chk("ram63", mem[63], 8'hEF);
        chk("ram0", mem[0], 8'hBE);

        // handshake: valid held high, second request queued behind the first
        req_we = 1'b1; req_word = 1'b0; req_addr = 6'd30; req_wdata = 16'h0011; req_valid = 1'b1;
        p0 = pulses;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 16'h0000;
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (req_ready) bad++;
        end while (!rsp_valid && n < 20);
        chk("hs_ready_low_busy", bad, 0);
        chk("hs_first_rsp", rsp_valid, 1);
        @(negedge clk);
        chk("hs_ready_after_done", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hs_second_latency", lat, 3);
        chk("hs_second_rdata", rsp_rdata, 16'h0011);
        @(negedge clk);
        chk("hs_pulses", pulses - p0, 2);
        model(1'b1, 1'b0, 6'd30, 16'h0011, erd, elat);
        model(1'b0, 1'b0, 6'd30, 16'h0000, erd, elat);

        // reset during WR1 of a word write
        bd_we = 1'b1; bd_addr = 6'd21; bd_data = 8'h77;
        @(negedge clk);
        bd_we = 1'b0;
        rmem[21] = 8'h77;
        req_we = 1'b1; req_word = 1'b1; req_addr = 6'd20; req_wdata = 16'hCAFE; req_valid = 1'b1;
        p0 = pulses;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_wr1_we", ram_we, 1);
        chk("mid_wr1_addr", ram_addr, 6'd21);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_data", ram_data, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_ram20", mem[20], 8'hFE);
        chk("mid_ram21", mem[21], 8'h77);
        rst_n = 1'b1;
        chk("mid_ready_after", req_ready, 1);
        repeat (3) @(negedge clk);
        chk("mid_no_rsp", pulses - p0, 0);
        chk("mid_rdata_cleared", rsp_rdata, 0);
        rmem[20] = 8'hFE;
        last_rd = 16'h0000;

        // randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom);
            wo = 1'($urandom);
            a  = 6'($urandom);
            d  = 16'($urandom);
            model(w, wo, a, d, erd, elat);
            xact(w, wo, a, d, lat, rd, np);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_pulses", i), np, 1);
        end
        for (int i = 0; i < 64; i++) chk($sformatf("final_ram%0d", i), mem[i], rmem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Initiator and sequencer for the 64x8 synchronous single-port RAM. It accepts byte or 16-bit word requests from the processor datapath over a valid/ready handshake. Each word request becomes two byte cycles: little-endian, low byte at A, high byte at A+1 mod 64. The block drives the RAM's Data/Addr/we pins and returns read data with a one-cycle response pulse.

Parameters:
ADDR_W, 6, RAM address width (64 locations)
DATA_W, 8, RAM data width; the request word is 2*DATA_W

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_we  in  1  1 = write, 0 = read
req_word  in  1  1 = 16-bit access, 0 = byte access
req_addr  in  ADDR_W  start address A
req_wdata  in  2*DATA_W  write data; [7:0] goes to A, [15:8] goes to A+1
rsp_valid  out  1  one-cycle pulse when a request completes (reads and writes)
rsp_rdata  out  2*DATA_W  read result; [15:8]=0 for byte reads
ram_addr  out  ADDR_W  to RAM Addr
ram_data  out  DATA_W  to RAM Data
ram_we  out  1  to RAM we
ram_q  in  DATA_W  from RAM X (registered read: valid the cycle after the address is presented with we=0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; latched req regs=0; rsp_valid=0; rsp_rdata=0; ram_we=0, ram_addr=0, ram_data=0 immediately, without waiting for a clock.
- States: IDLE, WR0, WR1, RD0, RD1, RD2, DONE.
- ram_* outputs decode only from the state register and the latched request, never from req_* inputs. ram_we=1 only in WR0/WR1. In IDLE and DONE, ram_* = 0.
- IDLE: req_ready=1. On posedge with req_valid=1, latch we, word, addr and wdata, then go to WR0 (we=1) or RD0 (we=0). When req_valid=0, stay in IDLE.
- WR0: ram_addr=A, ram_data=wdata[7:0], ram_we=1. Next state is WR1 if word=1, else DONE.
- WR1: ram_addr=(A+1) mod 64, ram_data=wdata[15:8], ram_we=1. Next state is DONE.
- RD0: ram_addr=A, ram_we=0. The RAM registers the byte at the end of this cycle. Next state is RD1.
- RD1: ram_q is valid. At the end of the cycle, capture rdata[7:0]<=ram_q.
  - Word read: also drive ram_addr=(A+1) mod 64 in this cycle; next state is RD2.
  - Byte read: rdata[15:8]<=0; next state is DONE.
- RD2: at the end of the cycle, capture rdata[15:8]<=ram_q. Next state is DONE.
- DONE: rsp_valid=1 for exactly one cycle. rsp_rdata is updated for reads only. Next state is IDLE.
- Latency from the accept edge to rsp_valid high: byte write 2 cycles, word write 3, byte read 3, word read 4. Back-to-back requests add 1 IDLE cycle.
- No response backpressure; the consumer must sample rsp_valid.
- rsp_rdata holds its last read value across writes and idle periods.
- Address arithmetic is 6-bit modular: A=63 word → high byte at address 0. Unaligned word addresses are legal.
- req_valid while busy is ignored (req_ready=0); the requester must hold the request until it sees ready.
- Reset mid-operation aborts with no response; bytes already written stay written. Example: a word write reset during WR1 leaves the low byte committed and the high byte not written.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W constants
  - state encoding localparams (IDLE..DONE, 3 bits)
  - WORD_W = 2*DATA_W
- No sub-module is needed; address increment and byte steering are inline.
- A bench top wires ram_access_ctrl to RAM: ram_data→Data, ram_addr→Addr, ram_we→we, X→ram_q.

Test Plan:
1. Byte write 0xA5 @5, then byte read @5:
   - RAM[5]=0xA5
   - write rsp_valid 2 cycles after accept
   - read rsp_rdata=0x00A5, rsp_valid 3 cycles after accept.
2. Word write 0x1234 @10, then word read @10:
   - RAM[10]=0x34, RAM[11]=0x12
   - rsp_rdata=0x1234, rsp_valid 4 cycles after the read accept.
3. Wrap: word write 0xBEEF @63, then word read @63:
   - RAM[63]=0xEF, RAM[0]=0xBE
   - rsp_rdata=0xBEEF.
4. Handshake: hold req_valid high continuously with two queued requests:
   - req_ready=0 throughout the busy states
   - the second request is accepted in the first IDLE cycle after DONE
   - exactly one rsp_valid pulse per request.
5. Reset mid-op: word write 0xCAFE @20 with RAM[21]=0x77, pull rst_n low during WR1 between edges:
   - ram_we falls to 0 immediately
   - RAM[20]=0xFE, RAM[21]=0x77
   - no rsp_valid
   - req_ready=1 after release.
6. Byte read @5 after a word read returned 0x1234, then a write:
   - rsp_rdata=0x00A5 (high byte cleared)
   - the subsequent write leaves rsp_rdata unchanged.
